block_dispatcher: RTL and testbench

Parametrised next-generation thread-block dispatcher for the GPU top level. It splits a kernel's thread count into blocks of THREADS_PER_BLOCK and hands blocks to compute cores round-robin, one grant per cycle. It honours a per-core enable mask, tracks completions, and signals kernel done. It sits between the device control register and the core array, replacing the fixed 8-bit dispatcher.

---
 rtl/block_dispatcher.sv | 142 ++++++++++++++
 tb/tb_block_dispatcher.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/block_dispatcher.sv
// block_dispatcher: splits a kernel into THREADS_PER_BLOCK-sized blocks and grants them
// round-robin to enabled idle cores. Define BLOCK_DISPATCHER_PERF_EN to add kernel_cycles.
module block_dispatcher #(
  parameter  int unsigned NUM_CORES         = 2,
  parameter  int unsigned THREADS_PER_BLOCK = 4,
  parameter  int unsigned TC_W              = 8,
  localparam int unsigned CT_W              = $clog2(THREADS_PER_BLOCK) + 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [TC_W-1:0]                thread_count,
  input  logic [NUM_CORES-1:0]           core_enable,
  input  logic [NUM_CORES-1:0]           core_done,
  output logic [NUM_CORES-1:0]           core_start,
  output logic [NUM_CORES-1:0]           core_reset,
  output logic [NUM_CORES-1:0][TC_W-1:0] core_block_id,
  output logic [NUM_CORES-1:0][CT_W-1:0] core_thread_count,
  output logic                           done,
  output logic                           busy,
  output logic [TC_W-1:0]                blocks_done
`ifdef BLOCK_DISPATCHER_PERF_EN
  ,
  output logic [31:0]                    kernel_cycles
`endif
);

  localparam int unsigned SH    = $clog2(THREADS_PER_BLOCK);
  localparam int unsigned PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t               state;
  logic [PTR_W-1:0]     rr_ptr;
  logic [TC_W-1:0]      kernel_tc;
  logic [TC_W-1:0]      total_blocks;
  logic [TC_W-1:0]      blocks_dispatched;
  logic [NUM_CORES-1:0] launch;

  logic                 accept;
  logic [NUM_CORES-1:0] eligible;
  logic [NUM_CORES-1:0] completions;
  logic [TC_W-1:0]      total_next;
  logic [TC_W-1:0]      last_tc;
  logic [CT_W-1:0]      grant_tc;
  logic                 grant_valid;
  logic [PTR_W-1:0]     grant_idx;

  assign accept      = start && (state == S_IDLE || state == S_DONE);
  // A core is busy from its load pulse until its done is sampled.
  assign eligible    = core_enable & ~core_start & ~launch;
  assign completions = core_start & core_done;

  assign total_next = (thread_count >> SH)
                    + TC_W'(|(thread_count & TC_W'(THREADS_PER_BLOCK - 1)));
  assign last_tc    = kernel_tc - ((total_blocks - TC_W'(1)) << SH);
  assign grant_tc   = (blocks_dispatched == total_blocks - TC_W'(1))
                    ? CT_W'(last_tc) : CT_W'(THREADS_PER_BLOCK);

  // Wrapped search as two passes: cores at or above rr_ptr first, then from core 0.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      if (!grant_valid && eligible[i] && i >= 32'(rr_ptr)) begin
        grant_valid = 1'b1;
        grant_idx   = PTR_W'(i);
      end
    end
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      if (!grant_valid && eligible[i]) begin
        grant_valid = 1'b1;
        grant_idx   = PTR_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= S_IDLE;
      rr_ptr            <= '0;
      kernel_tc         <= '0;
      total_blocks      <= '0;
      blocks_dispatched <= '0;
      launch            <= '0;
      core_reset        <= '1;
      core_start        <= '0;
      core_block_id     <= '0;
      core_thread_count <= '0;
      done              <= 1'b0;
      busy              <= 1'b0;
      blocks_done       <= '0;
    end else begin
      core_reset  <= '0;
      launch      <= '0;
      core_start  <= (core_start & ~core_done) | launch;
      blocks_done <= blocks_done + TC_W'($countones(completions));

      if (accept) begin
        kernel_tc         <= thread_count;
        total_blocks      <= total_next;
        blocks_dispatched <= '0;
        blocks_done       <= '0;
        if (thread_count == '0) begin
          state <= S_DONE;
          done  <= 1'b1;
          busy  <= 1'b0;
        end else begin
          state <= S_RUN;
          done  <= 1'b0;
          busy  <= 1'b1;
        end
      end else if (state == S_RUN) begin
        if (blocks_done == total_blocks) begin
          state <= S_DONE;
          done  <= 1'b1;
          busy  <= 1'b0;
        end else if (grant_valid && blocks_dispatched < total_blocks) begin
          core_reset[grant_idx]        <= 1'b1;
          launch[grant_idx]            <= 1'b1;
          core_block_id[grant_idx]     <= blocks_dispatched;
          core_thread_count[grant_idx] <= grant_tc;
          blocks_dispatched            <= blocks_dispatched + TC_W'(1);
          rr_ptr <= (32'(grant_idx) == NUM_CORES - 1) ? '0 : grant_idx + PTR_W'(1);
        end
      end
    end
  end

`ifdef BLOCK_DISPATCHER_PERF_EN
  always_ff @(posedge clk) begin
    if (reset || accept) begin
      kernel_cycles <= '0;
    end else if (state == S_RUN && kernel_cycles != '1) begin
      kernel_cycles <= kernel_cycles + 32'd1;
    end
  end
`else
  // No cycle counter in this build; dispatch behaviour is unchanged.
`endif

endmodule

// File: tb/tb_block_dispatcher.sv
// Self-checking bench for block_dispatcher: directed scenarios plus randomized kernels
// compared every cycle against a behavioural dispatch model.
`timescale 1ns/1ps
module tb_block_dispatcher;

  localparam int unsigned NC  = 2;
  localparam int unsigned TPB = 4;
  localparam int unsigned TW  = 8;
  localparam int unsigned CW  = $clog2(TPB) + 1;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   start;
  logic [TW-1:0]          thread_count;
  logic [NC-1:0]          core_enable;
  logic [NC-1:0]          core_done;
  logic [NC-1:0]          core_start;
  logic [NC-1:0]          core_reset;
  logic [NC-1:0][TW-1:0]  core_block_id;
  logic [NC-1:0][CW-1:0]  core_thread_count;
  logic                   done;
  logic                   busy;
  logic [TW-1:0]          blocks_done;
`ifdef BLOCK_DISPATCHER_PERF_EN
  logic [31:0]            kernel_cycles;
`endif

  block_dispatcher #(
    .NUM_CORES(NC),
    .THREADS_PER_BLOCK(TPB),
    .TC_W(TW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .thread_count(thread_count),
    .core_enable(core_enable),
    .core_done(core_done),
    .core_start(core_start),
    .core_reset(core_reset),
    .core_block_id(core_block_id),
    .core_thread_count(core_thread_count),
    .done(done),
    .busy(busy),
    .blocks_done(blocks_done)
`ifdef BLOCK_DISPATCHER_PERF_EN
    ,
    .kernel_cycles(kernel_cycles)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: kernel phase, per-core block ownership, counters as plain ints.
  typedef enum {M_IDLE, M_RUN, M_DONE} mphase_t;
  mphase_t m_phase = M_IDLE;
  int      m_tc, m_total, m_issued, m_bd, m_rr;
  bit      m_done, m_busy;
  bit      m_run[NC];
  bit      m_load[NC];
  bit      m_pend[NC];
  int      m_bid[NC];
  int      m_btc[NC];
  longint  m_kc;

  function automatic logic [NC-1:0] m_vec(input bit a[NC]);
    logic [NC-1:0] v;
    for (int i = 0; i < NC; i++) v[i] = a[i];
    return v;
  endfunction

  task automatic model_step();
    int g;
    int cnt;
    int c;
    if (reset) begin
      m_phase = M_IDLE; m_tc = 0; m_total = 0; m_issued = 0; m_bd = 0; m_rr = 0;
      m_done = 0; m_busy = 0; m_kc = 0;
      for (int i = 0; i < NC; i++) begin
        m_run[i] = 0; m_load[i] = 1; m_pend[i] = 0; m_bid[i] = 0; m_btc[i] = 0;
      end
      return;
    end
    g = -1;
    if (m_phase == M_RUN && m_bd != m_total && m_issued < m_total)
      for (int k = 0; k < NC; k++) begin
        c = (m_rr + k) % NC;
        if (g < 0 && core_enable[c] && !m_run[c] && !m_pend[c]) g = c;
      end
    if (m_phase == M_RUN && m_kc < 64'hFFFF_FFFF) m_kc++;
    cnt = 0;
    for (int i = 0; i < NC; i++) begin
      if (m_run[i] && core_done[i]) begin
        m_run[i] = 0;
        cnt++;
      end
      if (m_pend[i]) m_run[i] = 1;
      m_pend[i] = 0;
      m_load[i] = 0;
    end
    if (m_phase != M_RUN && start) begin
      m_tc = int'(thread_count);
      m_total = (m_tc + TPB - 1) / TPB;
      m_issued = 0; m_bd = 0; m_kc = 0;
      if (m_tc == 0) begin
        m_phase = M_DONE; m_done = 1; m_busy = 0;
      end else begin
        m_phase = M_RUN; m_done = 0; m_busy = 1;
      end
    end else begin
      if (m_phase == M_RUN) begin
        if (m_bd == m_total) begin
          m_phase = M_DONE; m_done = 1; m_busy = 0;
        end else if (g >= 0) begin
          m_load[g] = 1;
          m_pend[g] = 1;
          m_bid[g]  = m_issued;
          m_btc[g]  = (m_issued == m_total - 1) ? m_tc - (m_total - 1) * TPB : TPB;
          m_issued++;
          m_rr = (g + 1) % NC;
        end
      end
      m_bd = (m_bd + cnt) % (1 << TW);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_cmp++; if (core_reset !== 2'b11) begin n_bad++; $display("FAIL rst_core_reset: got %b want 11", core_reset); end
    n_cmp++; if (core_start !== 2'b00) begin n_bad++; $display("FAIL rst_core_start: got %b want 00", core_start); end
    n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL rst_done_busy: got %b%b want 00", done, busy); end
    n_cmp++; if (blocks_done !== '0) begin n_bad++; $display("FAIL rst_blocks_done: got %0d want 0", blocks_done); end
    n_cmp++; if (core_block_id !== '0 || core_thread_count !== '0) begin n_bad++; $display("FAIL rst_assign: got id %h tc %h want 0", core_block_id, core_thread_count); end
    reset = 1'b0;
    tick();
    n_cmp++; if (core_reset !== 2'b00) begin n_bad++; $display("FAIL rst_release_core_reset: got %b want 00", core_reset); end
    n_cmp++; if (core_start !== 2'b00 || busy !== 1'b0) begin n_bad++; $display("FAIL rst_release_idle: got start %b busy %b want 00/0", core_start, busy); end
  endtask

  task automatic test_basic();
    core_enable = '1;
    thread_count = TW'(6);
    start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++; if (busy !== 1'b1 || done !== 1'b0) begin n_bad++; $display("FAIL basic_run_entry: got busy %b done %b want 1/0", busy, done); end
    n_cmp++; if (core_reset !== 2'b00) begin n_bad++; $display("FAIL basic_no_early_grant: got %b want 00", core_reset); end
    tick();
    n_cmp++; if (core_reset !== 2'b01) begin n_bad++; $display("FAIL basic_grant0_pulse: got %b want 01", core_reset); end
    n_cmp++; if (core_block_id[0] !== TW'(0) || core_thread_count[0] !== CW'(4)) begin n_bad++; $display("FAIL basic_grant0_assign: got id %0d tc %0d want 0/4", core_block_id[0], core_thread_count[0]); end
    tick();
    n_cmp++; if (core_start !== 2'b01 || core_reset !== 2'b10) begin n_bad++; $display("FAIL basic_grant1: got start %b reset %b want 01/10", core_start, core_reset); end
    n_cmp++; if (core_block_id[1] !== TW'(1) || core_thread_count[1] !== CW'(2)) begin n_bad++; $display("FAIL basic_grant1_assign: got id %0d tc %0d want 1/2", core_block_id[1], core_thread_count[1]); end
    tick();
    n_cmp++; if (core_start !== 2'b11 || core_reset !== 2'b00) begin n_bad++; $display("FAIL basic_both_running: got start %b reset %b want 11/00", core_start, core_reset); end
    core_done = 2'b01;
    tick();
    core_done = 2'b00;
    n_cmp++; if (core_start !== 2'b10 || blocks_done !== TW'(1)) begin n_bad++; $display("FAIL basic_done0: got start %b bd %0d want 10/1", core_start, blocks_done); end
    core_done = 2'b10;
    tick();
    core_done = 2'b00;
    n_cmp++; if (core_start !== 2'b00 || blocks_done !== TW'(2) || done !== 1'b0) begin n_bad++; $display("FAIL basic_done1: got start %b bd %0d done %b want 00/2/0", core_start, blocks_done, done); end
    tick();
    n_cmp++; if (done !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL basic_kernel_done: got done %b busy %b want 1/0", done, busy); end
    tick();
    n_cmp++; if (done !== 1'b1 || core_block_id[1] !== TW'(1) || core_thread_count[1] !== CW'(2)) begin n_bad++; $display("FAIL basic_done_hold: got done %b id %0d tc %0d want 1/1/2", done, core_block_id[1], core_thread_count[1]); end
  endtask

  task automatic test_zero_threads();
    thread_count = TW'(0);
    start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++; if (done !== 1'b1 || busy !== 1'b0 || blocks_done !== '0) begin n_bad++; $display("FAIL zero_done: got done %b busy %b bd %0d want 1/0/0", done, busy, blocks_done); end
    for (int c = 0; c < 3; c++) begin
      n_cmp++; if (core_reset !== 2'b00 || core_start !== 2'b00) begin n_bad++; $display("FAIL zero_no_activity: got reset %b start %b want 00/00", core_reset, core_start); end
      tick();
    end
  endtask

  task automatic test_multi_block();
    int gc[$];
    int gid[$];
    int gtc[$];
    int cyc;
    int exp_core[5] = '{0, 1, 0, 1, 0};
    thread_count = TW'(17);
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 200) begin
      for (int i = 0; i < NC; i++)
        if (core_reset[i]) begin
          gc.push_back(i); gid.push_back(int'(core_block_id[i])); gtc.push_back(int'(core_thread_count[i]));
        end
      core_done = core_start;
      tick();
      cyc++;
    end
    core_done = '0;
    n_cmp++; if (cyc >= 200) begin n_bad++; $display("FAIL multi_timeout: got %0d cycles want <200", cyc); end
    n_cmp++; if (gc.size() != 5) begin n_bad++; $display("FAIL multi_grant_count: got %0d want 5", gc.size()); end
    for (int k = 0; k < 5 && k < gc.size(); k++) begin
      n_cmp++;
      if (gc[k] != exp_core[k] || gid[k] != k || gtc[k] != ((k == 4) ? 1 : 4)) begin
        n_bad++; $display("FAIL multi_grant[%0d]: got core %0d id %0d tc %0d want %0d/%0d/%0d", k, gc[k], gid[k], gtc[k], exp_core[k], k, (k == 4) ? 1 : 4);
      end
    end
    n_cmp++; if (blocks_done !== TW'(5) || done !== 1'b1) begin n_bad++; $display("FAIL multi_final: got bd %0d done %b want 5/1", blocks_done, done); end
  endtask

  task automatic test_enable_mask();
    int gc[$];
    int gid[$];
    int cyc;
    int run_len;
    int touched0;
    core_enable = 2'b10;
    thread_count = TW'(8);
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0; run_len = 0; touched0 = 0;
    while (!done && cyc < 200) begin
      if (core_reset[0] || core_start[0]) touched0++;
      if (core_reset[1]) begin gc.push_back(1); gid.push_back(int'(core_block_id[1])); end
      if (core_reset[0]) begin gc.push_back(0); gid.push_back(int'(core_block_id[0])); end
      run_len = core_start[1] ? run_len + 1 : 0;
      core_done = (run_len >= 2) ? 2'b10 : 2'b00;
      tick();
      cyc++;
    end
    core_done = '0;
    core_enable = '1;
    n_cmp++; if (cyc >= 200) begin n_bad++; $display("FAIL mask_timeout: got %0d cycles want <200", cyc); end
    n_cmp++; if (touched0 != 0) begin n_bad++; $display("FAIL mask_core0_idle: got %0d active cycles want 0", touched0); end
    n_cmp++; if (gc.size() != 2) begin n_bad++; $display("FAIL mask_grant_count: got %0d want 2", gc.size()); end
    for (int k = 0; k < 2 && k < gc.size(); k++) begin
      n_cmp++; if (gc[k] != 1 || gid[k] != k) begin n_bad++; $display("FAIL mask_grant[%0d]: got core %0d id %0d want 1/%0d", k, gc[k], gid[k], k); end
    end
    n_cmp++; if (blocks_done !== TW'(2) || done !== 1'b1 || core_thread_count[1] !== CW'(4)) begin n_bad++; $display("FAIL mask_final: got bd %0d done %b tc %0d want 2/1/4", blocks_done, done, core_thread_count[1]); end
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    int run_cycles;
    thread_count = TW'(8);
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (core_start !== 2'b11 && cyc < 20) begin tick(); cyc++; end
    n_cmp++; if (cyc >= 20) begin n_bad++; $display("FAIL midrst_setup_timeout: got start %b want 11", core_start); end
    reset = 1'b1;
    core_done = '1;
    tick();
    n_cmp++; if (core_reset !== 2'b11 || core_start !== 2'b00) begin n_bad++; $display("FAIL midrst_cores: got reset %b start %b want 11/00", core_reset, core_start); end
    n_cmp++; if (done !== 1'b0 || busy !== 1'b0 || blocks_done !== '0) begin n_bad++; $display("FAIL midrst_status: got done %b busy %b bd %0d want 0/0/0", done, busy, blocks_done); end
    n_cmp++; if (core_block_id !== '0 || core_thread_count !== '0) begin n_bad++; $display("FAIL midrst_assign: got id %h tc %h want 0", core_block_id, core_thread_count); end
    reset = 1'b0;
    tick();
    core_done = '0;
    n_cmp++; if (core_reset !== 2'b00 || core_start !== 2'b00 || blocks_done !== '0) begin n_bad++; $display("FAIL midrst_release: got reset %b start %b bd %0d want 00/00/0", core_reset, core_start, blocks_done); end
    thread_count = TW'(4);
    start = 1'b1;
    tick();
    start = 1'b0;
    run_cycles = busy ? 1 : 0;
    tick();
    n_cmp++; if (core_reset !== 2'b01 || core_block_id[0] !== TW'(0) || core_thread_count[0] !== CW'(4)) begin n_bad++; $display("FAIL midrst_restart_grant: got reset %b id %0d tc %0d want 01/0/4", core_reset, core_block_id[0], core_thread_count[0]); end
    cyc = 0;
    while (!done && cyc < 100) begin
      if (busy) run_cycles++;
      core_done = core_start;
      tick();
      cyc++;
    end
    core_done = '0;
    n_cmp++; if (cyc >= 100 || blocks_done !== TW'(1)) begin n_bad++; $display("FAIL midrst_restart_done: got bd %0d after %0d cycles want 1 within 100", blocks_done, cyc); end
`ifdef BLOCK_DISPATCHER_PERF_EN
    n_cmp++; if (kernel_cycles !== 32'(run_cycles)) begin n_bad++; $display("FAIL perf_count: got %0d want %0d", kernel_cycles, run_cycles); end
    tick();
    tick();
    n_cmp++; if (kernel_cycles !== 32'(run_cycles)) begin n_bad++; $display("FAIL perf_frozen: got %0d want %0d", kernel_cycles, run_cycles); end
`endif
  endtask

  task automatic test_random_kernels();
    int tcv;
    int cyc;
    int corner[6] = '{1, 4, 5, 255, 3, 16};
    logic [NC-1:0] e_load;
    logic [NC-1:0] e_run;
    for (int k = 0; k < 24; k++) begin
      tcv = (k < 6) ? corner[k] : int'($urandom_range(0, 60));
      repeat ($urandom_range(0, 2)) tick();
      thread_count = TW'(tcv);
      start = 1'b1;
      tick();
      start = 1'b0;
      cyc = 0;
      while (cyc < 3000) begin
        e_load = m_vec(m_load);
        e_run  = m_vec(m_run);
        n_cmp++; if (core_reset !== e_load) begin n_bad++; $display("FAIL rnd_core_reset k=%0d cyc=%0d: got %b want %b", k, cyc, core_reset, e_load); end
        n_cmp++; if (core_start !== e_run) begin n_bad++; $display("FAIL rnd_core_start k=%0d cyc=%0d: got %b want %b", k, cyc, core_start, e_run); end
        n_cmp++; if (done !== m_done || busy !== m_busy) begin n_bad++; $display("FAIL rnd_done_busy k=%0d cyc=%0d: got %b%b want %b%b", k, cyc, done, busy, m_done, m_busy); end
        n_cmp++; if (blocks_done !== TW'(m_bd)) begin n_bad++; $display("FAIL rnd_blocks_done k=%0d cyc=%0d: got %0d want %0d", k, cyc, blocks_done, m_bd); end
        for (int i = 0; i < NC; i++) begin
          n_cmp++; if (core_block_id[i] !== TW'(m_bid[i])) begin n_bad++; $display("FAIL rnd_block_id[%0d] k=%0d: got %0d want %0d", i, k, core_block_id[i], m_bid[i]); end
          n_cmp++; if (core_thread_count[i] !== CW'(m_btc[i])) begin n_bad++; $display("FAIL rnd_thread_count[%0d] k=%0d: got %0d want %0d", i, k, core_thread_count[i], m_btc[i]); end
        end
`ifdef BLOCK_DISPATCHER_PERF_EN
        n_cmp++; if (kernel_cycles !== 32'(m_kc)) begin n_bad++; $display("FAIL rnd_kernel_cycles k=%0d: got %0d want %0d", k, kernel_cycles, m_kc); end
`endif
        if (m_phase == M_DONE) break;
        core_enable = ($urandom_range(0, 7) == 0) ? '0 : NC'($urandom);
        for (int i = 0; i < NC; i++)
          core_done[i] = core_start[i] ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
        start = ($urandom_range(0, 15) == 0);
        tick();
        cyc++;
      end
      start = 1'b0;
      core_done = '0;
      n_cmp++; if (cyc >= 3000) begin n_bad++; $display("FAIL rnd_timeout k=%0d tc=%0d: still running after %0d cycles", k, tcv, cyc); end
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    thread_count = '0;
    core_enable = '1;
    core_done = '0;
    test_reset();
    test_basic();
    test_zero_threads();
    test_multi_block();
    test_enable_mask();
    test_reset_mid_run();
    test_random_kernels();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
